riscv_alu_tag_pipe: RTL and testbench
=====================================

Name: riscv_alu_tag_pipe

Overview:
Parametrised, registered successor of the tag ALU.
- Computes the destination-operand tag from the two source tags and the propagation mode taken from the Tag Propagation Register.
- Adds a one-stage valid/ready pipeline, an extended mode set, a tag-check policy with a sticky violation flag, and optional propagation statistics.
- Sits between ID-stage tag operand fetch and the tag register file write port.

Parameters:
TAG_WIDTH, 32, width of operand and result tags
MODE_WIDTH, 3, width of the propagation mode field
CNT_WIDTH, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
valid_i  in  1  input beat valid
ready_o  out  1  unit can accept a beat
operator_i  in  MODE_WIDTH  propagation mode
operand_a_i  in  TAG_WIDTH  source tag A
operand_b_i  in  TAG_WIDTH  source tag B
check_en_i  in  1  enable policy check for this beat
check_mask_i  in  TAG_WIDTH  forbidden tag bits
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts output beat
result_o  out  TAG_WIDTH  destination tag
rf_enable_tag_o  out  1  tag register file write enable for this beat
tag_exc_o  out  1  policy violation on this output beat
exc_sticky_o  out  1  sticky violation flag
clear_sticky_i  in  1  clear sticky flag
stat_writes_o  out  CNT_WIDTH  tag writes count (optional feature)
stat_viol_o  out  CNT_WIDTH  violations count (optional feature)

Behaviour:
- Reset (rst_n=0 at a rising edge): valid_o, result_o, rf_enable_tag_o, tag_exc_o, exc_sticky_o and all counters are 0. Reset mid-beat discards the held beat.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational).
  - Accept when valid_i && ready_o. The accepted beat appears on the outputs the next cycle, so latency is 1.
  - Output holds stable while valid_o && !ready_i.
  - Output clears when ready_i is high and there is no new accept.
  - Back-to-back throughput is 1 beat per cycle.
- Modes (operator_i):
  - 0 OLD: rf_enable_tag_o=0, result_o=0.
  - 1 AND: a&b.
  - 2 OR: a|b.
  - 3 CLEAR: 0.
  - 4 XOR: a^b.
  - 5 SET: all ones.
  - 6 PASS_A: a.
  - 7 PASS_B: b.
  - Modes 1–7 set rf_enable_tag_o=1.
  - Any code beyond 7 (MODE_WIDTH>3) behaves as OLD.
- Check: tag_exc = check_en_i && write && ((result & check_mask_i) != 0). It is registered with the beat.
- Sticky flag:
  - Set on the output handshake (valid_o && ready_i) of a beat with tag_exc_o=1.
  - Cleared by clear_sticky_i.
  - Simultaneous set and clear: set wins.
  - Remains 1 until cleared.
- Registered outputs only depend on the accepted beat; there is no combinational path from operands to outputs.

Optional Feature:
Macro TAG_PROP_STATS_EN.
- Defined:
  - stat_writes_o increments on each output handshake with rf_enable_tag_o=1.
  - stat_viol_o increments on each output handshake with tag_exc_o=1.
  - Both saturate at all ones and reset to 0.
  - clear_sticky_i also clears both counters; an increment in the same cycle wins, leaving the counter at 1.
- Undefined: both stat outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset then idle -> all outputs 0, ready_o=1.
- OR mode, a=0x0000_00F0, b=0x0000_000F, ready_i=1 -> next cycle valid_o=1, result_o=0x0000_00FF, rf_enable_tag_o=1.
- OLD mode beat -> valid_o=1, rf_enable_tag_o=0, result_o=0. Then an XOR beat with a=b=0xFFFF_FFFF -> result_o=0, rf_enable_tag_o=1.
- Backpressure: ready_i=0 for 3 cycles with an AND beat held plus a new valid_i -> ready_o=0, result_o stable, second beat issued the cycle after ready_i=1.
- Check: SET mode, check_en_i=1, mask=0x8000_0000 -> tag_exc_o=1, exc_sticky_o=1 after handshake. clear_sticky_i in the same cycle as a second violating handshake -> sticky stays 1.
- TAG_PROP_STATS_EN with CNT_WIDTH=2: 5 writing handshakes -> stat_writes_o=3 (saturated); clear_sticky_i -> 0.

Source files
------------

// File: rtl/riscv_alu_tag_pipe.sv
// -----------------------------------------------------------------------------
// riscv_alu_tag_pipe
// Registered tag-propagation ALU with a one-stage valid/ready pipeline.
// Computes the destination tag from two source tags and the propagation mode,
// applies a tag-check policy, and keeps a sticky violation flag.
//
// Optional feature macro: TAG_PROP_STATS_EN
//   defined   -> saturating write/violation counters on stat_*_o
//   undefined -> stat_*_o tied to 0, no counter flops
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   valid_i/ready_o   input beat handshake (ready_o is combinational)
//   operator_i        propagation mode
//   operand_a_i/_b_i  source tags
//   check_en_i        enable policy check for this beat
//   check_mask_i      forbidden tag bits
//   valid_o/ready_i   output beat handshake
//   result_o          destination tag
//   rf_enable_tag_o   tag register file write enable
//   tag_exc_o         policy violation on the output beat
//   exc_sticky_o      sticky violation flag
//   clear_sticky_i    clears sticky flag (and statistics counters)
//   stat_writes_o     tag write count
//   stat_viol_o       violation count
// -----------------------------------------------------------------------------
module riscv_alu_tag_pipe #(
    parameter int unsigned TAG_WIDTH  = 32,
    parameter int unsigned MODE_WIDTH = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [MODE_WIDTH-1:0] operator_i,
    input  logic [TAG_WIDTH-1:0]  operand_a_i,
    input  logic [TAG_WIDTH-1:0]  operand_b_i,
    input  logic                  check_en_i,
    input  logic [TAG_WIDTH-1:0]  check_mask_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [TAG_WIDTH-1:0]  result_o,
    output logic                  rf_enable_tag_o,
    output logic                  tag_exc_o,
    output logic                  exc_sticky_o,
    input  logic                  clear_sticky_i,
    output logic [CNT_WIDTH-1:0]  stat_writes_o,
    output logic [CNT_WIDTH-1:0]  stat_viol_o
);

    localparam logic [MODE_WIDTH-1:0] MODE_OLD    = MODE_WIDTH'(0);
    localparam logic [MODE_WIDTH-1:0] MODE_AND    = MODE_WIDTH'(1);
    localparam logic [MODE_WIDTH-1:0] MODE_OR     = MODE_WIDTH'(2);
    localparam logic [MODE_WIDTH-1:0] MODE_CLEAR  = MODE_WIDTH'(3);
    localparam logic [MODE_WIDTH-1:0] MODE_XOR    = MODE_WIDTH'(4);
    localparam logic [MODE_WIDTH-1:0] MODE_SET    = MODE_WIDTH'(5);
    localparam logic [MODE_WIDTH-1:0] MODE_PASS_A = MODE_WIDTH'(6);
    localparam logic [MODE_WIDTH-1:0] MODE_PASS_B = MODE_WIDTH'(7);

    // Combinational ALU result for the beat presented at the input
    logic [TAG_WIDTH-1:0] res_c;
    logic                 wen_c;
    logic                 exc_c;

    // Output stage registers
    logic                 valid_q,  valid_d;
    logic [TAG_WIDTH-1:0] result_q, result_d;
    logic                 wen_q,    wen_d;
    logic                 exc_q,    exc_d;
    logic                 sticky_q, sticky_d;

    logic accept;
    logic out_hs;

    // Mode decode; unknown codes behave like OLD (no write)
    always_comb begin
        res_c = '0;
        wen_c = 1'b1;
        case (operator_i)
            MODE_OLD:    wen_c = 1'b0;
            MODE_AND:    res_c = operand_a_i & operand_b_i;
            MODE_OR:     res_c = operand_a_i | operand_b_i;
            MODE_CLEAR:  res_c = '0;
            MODE_XOR:    res_c = operand_a_i ^ operand_b_i;
            MODE_SET:    res_c = '1;
            MODE_PASS_A: res_c = operand_a_i;
            MODE_PASS_B: res_c = operand_b_i;
            default:     wen_c = 1'b0;
        endcase
        exc_c = check_en_i && wen_c && ((res_c & check_mask_i) != '0);
    end

    // Handshake
    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;
    assign out_hs  = valid_q && ready_i;

    // Next state of the output stage and sticky flag
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        wen_d    = wen_q;
        exc_d    = exc_q;
        sticky_d = sticky_q;

        if (accept) begin
            valid_d  = 1'b1;
            result_d = res_c;
            wen_d    = wen_c;
            exc_d    = exc_c;
        end else if (ready_i) begin
            // Beat drained with nothing behind it: return outputs to idle
            valid_d  = 1'b0;
            result_d = '0;
            wen_d    = 1'b0;
            exc_d    = 1'b0;
        end

        // Set has priority over clear
        if (clear_sticky_i) begin
            sticky_d = 1'b0;
        end
        if (out_hs && exc_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            wen_q    <= 1'b0;
            exc_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            wen_q    <= wen_d;
            exc_q    <= exc_d;
            sticky_q <= sticky_d;
        end
    end

    assign valid_o         = valid_q;
    assign result_o        = result_q;
    assign rf_enable_tag_o = wen_q;
    assign tag_exc_o       = exc_q;
    assign exc_sticky_o    = sticky_q;

`ifdef TAG_PROP_STATS_EN
    logic [CNT_WIDTH-1:0] writes_q, writes_d;
    logic [CNT_WIDTH-1:0] viol_q,   viol_d;

    // Saturating counters; an increment in the clearing cycle restarts at 1
    always_comb begin
        writes_d = writes_q;
        viol_d   = viol_q;

        if (out_hs && wen_q) begin
            if (clear_sticky_i) begin
                writes_d = CNT_WIDTH'(1);
            end else if (writes_q != '1) begin
                writes_d = writes_q + CNT_WIDTH'(1);
            end
        end else if (clear_sticky_i) begin
            writes_d = '0;
        end

        if (out_hs && exc_q) begin
            if (clear_sticky_i) begin
                viol_d = CNT_WIDTH'(1);
            end else if (viol_q != '1) begin
                viol_d = viol_q + CNT_WIDTH'(1);
            end
        end else if (clear_sticky_i) begin
            viol_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            writes_q <= '0;
            viol_q   <= '0;
        end else begin
            writes_q <= writes_d;
            viol_q   <= viol_d;
        end
    end

    assign stat_writes_o = writes_q;
    assign stat_viol_o   = viol_q;
`else
    assign stat_writes_o = '0;
    assign stat_viol_o   = '0;
`endif

endmodule

// File: tb/tb_riscv_alu_tag_pipe.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu_tag_pipe
// Table-driven vectors and hand sequences fed through a scoreboard queue:
// the expected beat is pushed when the input handshake happens and compared
// while it sits on the outputs.
// -----------------------------------------------------------------------------
module tb_riscv_alu_tag_pipe;

`ifdef TAG_PROP_STATS_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 16;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        wen;
        logic        exc;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        chk;
        logic [31:0] mask;
        exp_t        e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       operator_i;
    logic [31:0]      operand_a_i;
    logic [31:0]      operand_b_i;
    logic             check_en_i;
    logic [31:0]      check_mask_i;
    logic             valid_o;
    logic             ready_i;
    logic [31:0]      result_o;
    logic             rf_enable_tag_o;
    logic             tag_exc_o;
    logic             exc_sticky_o;
    logic             clear_sticky_i;
    logic [CNT_W-1:0] stat_writes_o;
    logic [CNT_W-1:0] stat_viol_o;

    riscv_alu_tag_pipe #(
        .TAG_WIDTH (32),
        .MODE_WIDTH(3),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .operator_i     (operator_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .check_en_i     (check_en_i),
        .check_mask_i   (check_mask_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .result_o       (result_o),
        .rf_enable_tag_o(rf_enable_tag_o),
        .tag_exc_o      (tag_exc_o),
        .exc_sticky_o   (exc_sticky_o),
        .clear_sticky_i (clear_sticky_i),
        .stat_writes_o  (stat_writes_o),
        .stat_viol_o    (stat_viol_o)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];
    exp_t cur_exp;
    vec_t vecs[12];

    logic             exp_sticky;
    logic [CNT_W-1:0] exp_wr;
    logic [CNT_W-1:0] exp_vi;
    logic             had;
    logic             hs;
    exp_t             f;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic chk, input logic [31:0] mask);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.chk = chk; v.mask = mask;
        v.e.wen = 1'b1;
        case (op)
            3'd0: begin v.e.res = '0; v.e.wen = 1'b0; end
            3'd1: v.e.res = a & b;
            3'd2: v.e.res = a | b;
            3'd3: v.e.res = '0;
            3'd4: v.e.res = a ^ b;
            3'd5: v.e.res = '1;
            3'd6: v.e.res = a;
            default: v.e.res = b;
        endcase
        v.e.exc = chk && v.e.wen && ((v.e.res & mask) != 0);
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Drive one cycle of stimulus, return 1ns after the rising edge
    task automatic drive(input logic v, input vec_t t, input logic rdy, input logic clr);
        valid_i        = v;
        operator_i     = t.op;
        operand_a_i    = t.a;
        operand_b_i    = t.b;
        check_en_i     = t.chk;
        check_mask_i   = t.mask;
        ready_i        = rdy;
        clear_sticky_i = clr;
        cur_exp        = t.e;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_sticky = 1'b0;
            exp_wr     = '0;
            exp_vi     = '0;
        end else begin
            had = (sb.size() != 0);
            f   = had ? sb[0] : exp_t'(0);
            check("valid_o", 32'(valid_o), 32'(had));
            check("ready_o", 32'(ready_o), 32'(!had || ready_i));
            check("result_o", result_o, f.res);
            check("rf_enable_tag_o", 32'(rf_enable_tag_o), 32'(f.wen));
            check("tag_exc_o", 32'(tag_exc_o), 32'(f.exc));
            check("exc_sticky_o", 32'(exc_sticky_o), 32'(exp_sticky));
            check("stat_writes_o", 32'(stat_writes_o), 32'(exp_wr));
            check("stat_viol_o", 32'(stat_viol_o), 32'(exp_vi));

            hs = had && ready_i;
            if (hs) void'(sb.pop_front());
            if (hs && f.exc) exp_sticky = 1'b1;
            else if (clear_sticky_i) exp_sticky = 1'b0;
`ifdef TAG_PROP_STATS_EN
            if (hs && f.wen) exp_wr = clear_sticky_i ? CNT_W'(1) : sat_inc(exp_wr);
            else if (clear_sticky_i) exp_wr = '0;
            if (hs && f.exc) exp_vi = clear_sticky_i ? CNT_W'(1) : sat_inc(exp_vi);
            else if (clear_sticky_i) exp_vi = '0;
`endif
            if (valid_i && (!had || ready_i)) sb.push_back(cur_exp);
        end
    end

    initial begin
        vec_t idle;
        vec_t r;
        idle = '0;

        // {op, a, b, chk, mask, {res, wen, exc}}
        vecs[0]  = '{3'd2, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0,         '{32'h0000_00FF, 1'b1, 1'b0}};
        vecs[1]  = '{3'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, 32'h0,         '{32'h0,         1'b0, 1'b0}};
        vecs[2]  = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0,         '{32'h0,         1'b1, 1'b0}};
        vecs[3]  = '{3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0,         '{32'hF000_F000, 1'b1, 1'b0}};
        vecs[4]  = '{3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'hFFFF_FFFF, '{32'h0,         1'b1, 1'b0}};
        vecs[5]  = '{3'd5, 32'h0,         32'h0,         1'b1, 32'h8000_0000, '{32'hFFFF_FFFF, 1'b1, 1'b1}};
        vecs[6]  = '{3'd6, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 32'h0,         '{32'hDEAD_BEEF, 1'b1, 1'b0}};
        vecs[7]  = '{3'd7, 32'h2222_2222, 32'hCAFE_F00D, 1'b0, 32'h0,         '{32'hCAFE_F00D, 1'b1, 1'b0}};
        vecs[8]  = '{3'd6, 32'hDEAD_BEEE, 32'h0,         1'b1, 32'h0000_0001, '{32'hDEAD_BEEE, 1'b1, 1'b0}};
        vecs[9]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, '{32'h0,         1'b0, 1'b0}};
        vecs[10] = '{3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, '{32'h0000_0001, 1'b1, 1'b0}};
        vecs[11] = '{3'd4, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0010, '{32'h0000_0010, 1'b1, 1'b1}};

        // Reset and idle state
        rst_n = 1'b0;
        drive(1'b0, idle, 1'b0, 1'b0);
        drive(1'b0, idle, 1'b0, 1'b0);
        check("rst valid_o", 32'(valid_o), 32'h0);
        check("rst result_o", result_o, 32'h0);
        check("rst rf_enable", 32'(rf_enable_tag_o), 32'h0);
        check("rst tag_exc", 32'(tag_exc_o), 32'h0);
        check("rst sticky", 32'(exc_sticky_o), 32'h0);
        check("rst ready_o", 32'(ready_o), 32'h1);
        check("rst stats", 32'(stat_writes_o) | 32'(stat_viol_o), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, idle, 1'b1, 1'b0);

        // Table vectors back to back
        for (int i = 0; i < 12; i++) drive(1'b1, vecs[i], 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b1);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Backpressure: AND beat held for 3 cycles while an OR beat waits
        drive(1'b1, mk(3'd1, 32'h0000_0F0F, 32'h0000_00FF, 1'b0, 32'h0), 1'b1, 1'b0);
        r = mk(3'd2, 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, r, 1'b0, 1'b0);
            check("bp ready_o", 32'(ready_o), 32'h0);
            check("bp result held", result_o, 32'h0000_000F);
        end
        drive(1'b1, r, 1'b1, 1'b0);
        check("bp second beat", result_o, 32'h0000_0101);
        drive(1'b0, idle, 1'b1, 1'b0);

        // Sticky: set on handshake, set wins over simultaneous clear
        r = mk(3'd5, 32'h0, 32'h0, 1'b1, 32'h8000_0000);
        drive(1'b1, r, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);
        check("sticky set", 32'(exc_sticky_o), 32'h1);
        drive(1'b1, r, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b1);
        check("sticky set wins", 32'(exc_sticky_o), 32'h1);
        drive(1'b0, idle, 1'b1, 1'b1);
        check("sticky cleared", 32'(exc_sticky_o), 32'h0);

        // A held violating beat does not set sticky before its handshake
        drive(1'b1, r, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b0, 1'b0);
        drive(1'b0, idle, 1'b0, 1'b0);
        check("sticky waits hs", 32'(exc_sticky_o), 32'h0);
        drive(1'b0, idle, 1'b1, 1'b0);
        check("sticky after hs", 32'(exc_sticky_o), 32'h1);
        drive(1'b0, idle, 1'b1, 1'b1);

        // Five writing handshakes, then clear
        for (int i = 0; i < 5; i++) drive(1'b1, mk(3'd6, 32'(i), 32'h0, 1'b0, 32'h0), 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);
`ifdef TAG_PROP_STATS_EN
        check("stat_writes sat", 32'(stat_writes_o), 32'h3);
`else
        check("stat_writes off", 32'(stat_writes_o), 32'h0);
`endif
        drive(1'b0, idle, 1'b1, 1'b1);
        check("stat_writes clr", 32'(stat_writes_o), 32'h0);

        // Reset while a beat is held
        drive(1'b1, mk(3'd6, 32'hAAAA_5555, 32'h0, 1'b0, 32'h0), 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, idle, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("midrst valid_o", 32'(valid_o), 32'h0);
        check("midrst result_o", result_o, 32'h0);

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            r = mk(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom),
                   $urandom & $urandom & $urandom);
            drive(1'($urandom), r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end
        drive(1'b0, idle, 1'b1, 1'b0);
        drive(1'b0, idle, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
